// File: rtl/fifo_mux_out_4b_if.sv
// Bus between the 4:1 mux output stage, the output FIFO and its consumer.
//   master : producer/consumer side; drives data_in, valid_in, pop and observes
//            read data, status flags, occupancy and the sticky error.
//   slave  : FIFO side; the mirror image of master.
// count is log2(DEPTH)+1 bits wide so it can represent 0..DEPTH inclusive.
interface fifo_mux_out_4b_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              error;

  modport master (
    output data_in, valid_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );

  modport slave (
    input  data_in, valid_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );
endinterface

// File: rtl/fifo_mux_out_4b.sv
// Synchronous FIFO buffering the valid words of the 4:1 4-bit mux.
//   clk    : rising-edge clock.
//   reset  : asynchronous, active-high; clears pointers, count, read data,
//            valid_out and error (storage contents are left as-is).
//   bus    : fifo_mux_out_4b_if slave modport
//            data_in/valid_in : push side (mux data_out / valid_data_out).
//            pop              : consumer read request.
//            data_out         : registered read data, holds when no pop.
//            valid_out        : one-cycle strobe for a freshly popped word.
//            full/empty/almost_full/almost_empty : decodes of count.
//            count            : occupancy 0..DEPTH.
//            error            : sticky overflow/underflow flag.
// DEPTH must be a power of two (>= 4) so the pointers wrap by overflow.
module fifo_mux_out_4b #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_mux_out_4b_if.slave      bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              error_q, error_d;

  logic              full;
  logic              empty;
  logic              pop_ok;
  logic              push_ok;
  logic              overflow;
  logic              underflow;

  // Flags decode the count register directly, so they only move after a clock edge.
  assign full  = (count_q == FULL_LVL);
  assign empty = (count_q == '0);

  // A pop frees a slot on the same edge, which lets a push into a full FIFO through.
  assign pop_ok    = bus.pop && !empty;
  assign push_ok   = bus.valid_in && (!full || pop_ok);
  assign overflow  = bus.valid_in && !push_ok;
  assign underflow = bus.pop && empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    error_d     = error_q | overflow | underflow;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop_ok) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
    end
  end

  // Storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_LVL);
  assign bus.almost_empty = (count_q <= AE_LVL);
  assign bus.count        = count_q;
  assign bus.error        = error_q;

endmodule
